// File: rtl/controller_fsm.sv
// Multi-cycle RISC-V style main controller.
// Sequences fetch, decode, memory access, execute and write-back for
// lw, sw, R-type, I-type ALU, beq and jal, stalling on mem_ready.
//
// state    | code | meaning
// ---------+------+------------------------------------------------------
// FETCH    |  0   | read instruction at PC, PC <- PC+4 when access completes
// DECODE   |  1   | compute branch/jump target old PC + imm, pick path
// MEMADR   |  2   | effective address rs1 + imm
// MEMREAD  |  3   | data read at ALU result address, wait for mem_ready
// MEMWB    |  4   | write loaded data to register file
// MEMWRITE |  5   | data write at ALU result address, wait for mem_ready
// EXECR    |  6   | rs1 op rs2
// EXECI    |  7   | rs1 op imm
// ALUWB    |  8   | write ALU output register to register file
// BEQ      |  9   | compare rs1/rs2, load PC with target when equal
// JAL      | 10   | link old PC + 4, load PC with target
// 11..15   |  -   | unused, recover to FETCH
module controller_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] imm_src,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_t state_q;
    state_t state_d;

    assign state = state_q;

    // State register; reset wins over any pending transition, including memory waits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Immediate format depends only on the opcode, independent of state.
    always_comb begin
        case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    // Next-state and control outputs; every output defaults to 0.
    // Strobes in wait states are level signals for the single pending access,
    // so holding them while mem_ready is low still counts as one write.
    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        illegal_op = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        state_d    = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b00;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = 2'b00;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b00;
                alu_op     = 2'b01;
                result_src = 2'b00;
                pc_write   = zero;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                alu_op     = 2'b00;
                result_src = 2'b00;
                pc_write   = 1'b1;
                state_d    = S_ALUWB;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_controller_fsm.sv
// Self-checking bench for controller_fsm: directed instruction scenarios
// followed by randomized instruction streams, all compared against an
// instruction-path reference model.
module tb_controller_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, adr_src, mem_write, ir_write, pc_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
    logic       illegal_op;
    logic [3:0] state;

    int n_assert = 0;
    int n_fail   = 0;

    controller_fsm dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .adr_src(adr_src), .mem_write(mem_write),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .imm_src(imm_src), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;

    // Per-state control tables, indexed by state number 0..10.
    localparam logic [10:0] T_MEM_REQ   = 11'b00000101001; // 0,3,5
    localparam logic [10:0] T_ADR_SRC   = 11'b00000101000; // 3,5
    localparam logic [10:0] T_MEM_WRITE = 11'b00000100000; // 5
    localparam logic [10:0] T_REG_WRITE = 11'b00100010000; // 4,8
    localparam logic [1:0] T_RES  [11] = '{2'd2, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    localparam logic [1:0] T_SRCA [11] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd0, 2'd2, 2'd1};
    localparam logic [1:0] T_SRCB [11] = '{2'd2, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd2};
    localparam logic [1:0] T_ALUOP[11] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd0, 2'd1, 2'd0};

    // Reference model: the instruction's whole state path is chosen when it
    // leaves FETCH; the model walks it, pausing in memory-wait states.
    int m_path[$];
    int m_pos;
    int m_state;

    logic [3:0]  snap_state;
    logic        snap_mem_write, snap_reg_write, snap_pc_write, snap_illegal;
    logic [1:0]  snap_alu_op, snap_result_src;

    function automatic bit is_legal(input logic [6:0] o);
        return (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == BQ) || (o == JL);
    endfunction

    function automatic void start_path(input logic [6:0] o);
        m_path = '{0, 1};
        case (o)
            LW: m_path = '{0, 1, 2, 3, 4};
            SW: m_path = '{0, 1, 2, 5};
            RT: m_path = '{0, 1, 6, 8};
            IT: m_path = '{0, 1, 7, 8};
            BQ: m_path = '{0, 1, 9};
            JL: m_path = '{0, 1, 10, 8};
            default: m_path = '{0, 1};
        endcase
    endfunction

    function automatic logic [16:0] expect_ctl(input int s, input logic [6:0] o,
                                               input logic z, input logic r);
        logic       e_ir, e_pc, e_ill;
        logic [1:0] e_imm;
        e_ir  = (s == 0) && r;
        e_pc  = ((s == 0) && r) || ((s == 9) && z) || (s == 10);
        e_ill = (s == 1) && !is_legal(o);
        e_imm = (o == SW) ? 2'd1 : (o == BQ) ? 2'd2 : (o == JL) ? 2'd3 : 2'd0;
        return {T_MEM_REQ[s], T_ADR_SRC[s], T_MEM_WRITE[s], e_ir, e_pc, T_REG_WRITE[s],
                T_RES[s], T_SRCA[s], T_SRCB[s], T_ALUOP[s], e_imm, e_ill};
    endfunction

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_path  = '{0};
        m_pos   = 0;
        m_state = 0;
    endtask

    // One clock: drive inputs, check against model mid-cycle, advance model at the edge.
    task automatic cycle(input logic [6:0] o, input logic z, input logic r, input logic rn);
        logic [16:0] obs_ctl;
        op = o; zero = z; mem_ready = r; rst_n = rn;
        #2;
        snap_state      = state;
        snap_mem_write  = mem_write;
        snap_reg_write  = reg_write;
        snap_pc_write   = pc_write;
        snap_illegal    = illegal_op;
        snap_alu_op     = alu_op;
        snap_result_src = result_src;
        obs_ctl = {mem_req, adr_src, mem_write, ir_write, pc_write, reg_write,
                   result_src, alu_src_a, alu_src_b, alu_op, imm_src, illegal_op};
        chk("state", 32'(state), 32'(m_state));
        chk("ctl", 32'(obs_ctl), 32'(expect_ctl(m_state, o, z, r)));
        @(posedge clk);
        #1;
        if (!rn) begin
            model_reset();
        end else if (((m_state == 0) || (m_state == 3) || (m_state == 5)) && !r) begin
            // waiting on memory
        end else if (m_state == 0) begin
            start_path(o);
            m_pos   = 1;
            m_state = m_path[1];
        end else begin
            m_pos++;
            if (m_pos >= m_path.size()) model_reset();
            else m_state = m_path[m_pos];
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] rop;
        logic [6:0] legal [6];
        int         mw_cnt;
        legal = '{LW, SW, RT, IT, BQ, JL};

        rst_n = 1'b0; op = 7'd0; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        model_reset();

        // Reset state: FETCH outputs with strobes gated by mem_ready.
        cycle(LW, 0, 0, 1);
        chk("rst_state", 32'(snap_state), 32'd0);
        chk("rst_pcw_gated", 32'(snap_pc_write), 32'd0);

        // lw with mem_ready high throughout: 0,1,2,3,4,0.
        cycle(LW, 0, 1, 1); chk("lw_s0", 32'(snap_state), 32'd0);
        cycle(LW, 0, 1, 1); chk("lw_s1", 32'(snap_state), 32'd1);
        chk("lw_rw_dec", 32'(snap_reg_write), 32'd0);
        cycle(LW, 0, 1, 1); chk("lw_s2", 32'(snap_state), 32'd2);
        cycle(LW, 0, 1, 1); chk("lw_s3", 32'(snap_state), 32'd3);
        cycle(LW, 0, 1, 1); chk("lw_s4", 32'(snap_state), 32'd4);
        chk("lw_rw", 32'(snap_reg_write), 32'd1);
        chk("lw_res", 32'(snap_result_src), 32'd1);
        cycle(LW, 0, 0, 1); chk("lw_back", 32'(snap_state), 32'd0);

        // sw with three stall cycles in MEMWRITE.
        cycle(SW, 0, 1, 1);
        cycle(SW, 0, 1, 1);
        cycle(SW, 0, 1, 1);
        mw_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(SW, 0, (i == 3), 1);
            if (snap_mem_write) mw_cnt++;
        end
        chk("sw_mw_cycles", 32'(mw_cnt), 32'd4);
        cycle(SW, 0, 0, 1); chk("sw_back", 32'(snap_state), 32'd0);
        chk("sw_mw_off", 32'(snap_mem_write), 32'd0);

        // beq taken and not taken.
        for (int t = 1; t >= 0; t--) begin
            cycle(BQ, t[0], 1, 1);
            cycle(BQ, t[0], 1, 1);
            cycle(BQ, t[0], 1, 1);
            chk("beq_state", 32'(snap_state), 32'd9);
            chk("beq_aluop", 32'(snap_alu_op), 32'd1);
            chk("beq_pcw", 32'(snap_pc_write), 32'(t));
        end

        // R-type then jal.
        cycle(RT, 0, 1, 1);
        cycle(RT, 0, 1, 1);
        cycle(RT, 0, 1, 1); chk("r_aluop", 32'(snap_alu_op), 32'd2);
        cycle(RT, 0, 1, 1); chk("r_rw", 32'(snap_reg_write), 32'd1);
        cycle(JL, 0, 1, 1); chk("jal_s0", 32'(snap_state), 32'd0);
        cycle(JL, 0, 1, 1); chk("jal_s1", 32'(snap_state), 32'd1);
        cycle(JL, 0, 1, 1); chk("jal_s10", 32'(snap_state), 32'd10);
        chk("jal_pcw", 32'(snap_pc_write), 32'd1);
        cycle(JL, 0, 1, 1); chk("jal_s8", 32'(snap_state), 32'd8);
        cycle(JL, 0, 0, 1); chk("jal_back", 32'(snap_state), 32'd0);

        // Unsupported opcode.
        cycle(7'd0, 0, 1, 1); chk("ill_fetch", 32'(snap_illegal), 32'd0);
        cycle(7'd0, 0, 1, 1); chk("ill_dec", 32'(snap_illegal), 32'd1);
        cycle(7'd0, 0, 0, 1); chk("ill_back", 32'(snap_state), 32'd0);
        chk("ill_once", 32'(snap_illegal), 32'd0);

        // Reset held for two cycles while stalled in MEMWRITE.
        cycle(SW, 0, 1, 1);
        cycle(SW, 0, 1, 1);
        cycle(SW, 0, 1, 1);
        cycle(SW, 0, 0, 1); chk("rmw_in", 32'(snap_state), 32'd5);
        cycle(SW, 0, 0, 0);
        cycle(SW, 0, 0, 0);
        chk("rmw_state", 32'(snap_state), 32'd0);
        chk("rmw_mw", 32'(snap_mem_write), 32'd0);

        // Randomized instruction streams; opcode is held from the FETCH
        // handoff until the instruction returns to FETCH, as an IR would.
        rop = LW;
        for (int i = 0; i < 600; i++) begin
            if (m_state == 0) begin
                if ($urandom_range(0, 5) == 0) rop = 7'($urandom_range(0, 127));
                else rop = legal[$urandom_range(0, 5)];
            end
            cycle(rop, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 39) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
